schmidl_cox_metric: RTL and testbench
=====================================

Name: schmidl_cox_metric

Overview:
- Upstream neighbour of the Schmidl-Cox detector in the OFDM receive chain.
- Computes the unnormalised timing metric M[n] = |P[n]|^2, where P[n] = sum over k=0..L-1 of x[n-k]·conj(x[n-k-L]) and L = HALF_FFT_SIZE.
- Emits two lockstep AXI-Stream outputs: the sample x[n] and its metric M[n]. These feed the detector's sample and metric inputs directly.

Parameters:
- HALF_FFT_SIZE, 512: correlation lag and window L. Must be a power of two, at least 4.
- M_TDATA_WIDTH, 64: metric width. Only 64 is supported; elaboration fails otherwise.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous, active-high flush.
- i_tdata, input, 32: sample {I[31:16], Q[15:0]}, signed Q15.
- i_tlast, input, 1: end of packet.
- i_tvalid, input, 1: input beat valid.
- i_tready, output, 1: input beat accepted.
- o_tdata, output, 32: sample x[n], unmodified.
- o_tlast, output, 1: i_tlast carried with x[n].
- o_tvalid, output, 1: sample beat valid.
- o_tready, input, 1: sample beat consumed.
- m_tdata, output, 64: metric M[n], unsigned.
- m_tlast, output, 1: equal to o_tlast.
- m_tvalid, output, 1: metric beat valid; always equal to o_tvalid.
- m_tready, input, 1: metric beat consumed.

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage valid bits = 0; o_tvalid = m_tvalid = 0.
  - o_tdata = m_tdata = 0; accumulators = 0; fill counters = 0.
  - i_tready = 1 after reset deasserts.
- clear=1 is synchronous and does the same as reset. In-flight beats are dropped; clear has priority over any handshake in the same cycle.
- Pipeline: 4 stages with one global advance enable.
  - en = !out_valid | (o_tready & m_tready).
  - i_tready = en. Input is accepted when i_tvalid & en.
  - Each stage's valid and data advance only when en=1.
- Output consumption:
  - An output beat is consumed only when o_tready & m_tready are both high. One ready alone consumes nothing.
  - Outputs are held stable while valid and not consumed.
- Latency: a beat accepted at cycle t is output-valid at cycle t+4 if there are no stalls. Full throughput of 1 beat/cycle.
- S1 (delay-line lookup):
  - Register x.
  - Read d = x[n-L] from a circular sample delay line of depth L.
  - While fewer than L samples have been accepted since reset/clear, d reads as 0.
- S2 (conjugate product):
  - p_re = xi·di + xq·dq; p_im = xq·di − xi·dq.
  - Each is 33-bit signed, so 2^31 is representable.
- S3 (running sum):
  - P = P + p − p_old. P is (33+log2 L)-bit signed per component, with no saturation.
  - p_old comes from a second depth-L delay line holding 66-bit {p_re, p_im}. It reads as 0 until L products have been written.
  - Wrap-around cannot occur within range, so the sum is exact.
- S4 (metric):
  - Pq = P >>> (log2 L + 1) (arithmetic shift, truncation), taken as 32-bit signed.
  - M = Pq_re^2 + Pq_im^2, 64-bit unsigned; cannot overflow.
- tlast:
  - Travels with its sample to o_tlast/m_tlast.
  - Does not reset accumulators or delay lines; correlation spans packet boundaries.
- Delay-line read/write:
  - Both lines read and write the same address (write pointer) in the same enabled cycle, read-before-write.
  - Pointers wrap at L−1 → 0.
  - Fill counters saturate at L.

Decomposition:
- Package schmidl_cox_pkg:
  - SAMPLE_W=16, PROD_W=33, acc_width(L) function.
  - Packed struct cplx_t {re, im} for samples.
  - Wide struct cplx_prod_t for products and accumulators.
- Sub-module sc_delay_line, instantiated twice (sample line, product line):
  - Parameters DEPTH, WIDTH.
  - Inputs en, din; output dout = value written DEPTH enables earlier, else 0.
  - Internal wrap pointer and saturating fill counter; RAM-inferable.

Test Plan:
- Reset: hold reset=0 with i_tvalid=1 → o_tvalid=m_tvalid=0, i_tready=0. One cycle after release, i_tready=1.
- L=8, constant x=(1000,0), both readies=1:
  - M=0 for n<8.
  - For 8≤n<16, P_re=(n−7)·10^6; at n=8, Pq=62500 and M=3906250000.
  - For n≥15, M=250000000000 steady.
  - Each output appears 4 cycles after its input.
- L=8, constant x=(−32768,−32768) → steady P_re=2^34, Pq=2^30, M=2^60, P_im=0. No overflow.
- Random stream with o_tready held 0 for 10 cycles while m_tready=1 → i_tready drops, no beat consumed, outputs stable. After release, output sequence matches the golden model with no loss or duplication.
- Random readies plus tlast every 20 beats → o_tlast and m_tlast are identical and aligned with original samples; metric continuous across the boundary.
- clear pulse after 30 samples → all valids drop next cycle. Next 8 accepted samples yield M=0. Output resumes correctly thereafter.

Source files
------------

// File: rtl/schmidl_cox_pkg.sv
// Shared types and arithmetic helpers for the Schmidl-Cox timing-metric datapath.
// Samples are signed Q15 {I, Q}; products carry one guard bit so 2^31 is representable.
package schmidl_cox_pkg;

    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 33;

    // Running-sum width: one product plus log2(L) bits of growth over the window.
    function automatic int acc_width(input int half_len);
        return PROD_W + $clog2(half_len);
    endfunction

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] re;
        logic signed [PROD_W-1:0] im;
    } cplx_prod_t;

    function automatic logic signed [31:0] mul_s16(input logic signed [SAMPLE_W-1:0] a,
                                                   input logic signed [SAMPLE_W-1:0] b);
        logic signed [31:0] a_ext;
        logic signed [31:0] b_ext;
        a_ext = {{16{a[SAMPLE_W-1]}}, a};
        b_ext = {{16{b[SAMPLE_W-1]}}, b};
        return a_ext * b_ext;
    endfunction

    // Square of a signed 32-bit value; the low 64 bits of the product are exact.
    function automatic logic [63:0] sq_s32(input logic signed [31:0] a);
        logic [63:0] a_ext;
        a_ext = {{32{a[31]}}, a};
        return a_ext * a_ext;
    endfunction

endpackage

// File: rtl/sc_delay_line.sv
// Circular delay line: dout is the value written DEPTH enables ago, or 0 until DEPTH writes.
// Read and write share the pointer in the same enabled cycle (read-before-write).
module sc_delay_line #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;

    always_comb begin
        ptr_d  = ptr_q;
        fill_d = fill_q;
        if (clear) begin
            ptr_d  = '0;
            fill_d = '0;
        end else if (en) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            fill_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            fill_q <= fill_d;
        end
    end

    // Storage is left unreset so it maps onto RAM; the fill counter masks stale contents.
    always_ff @(posedge clk) begin
        if (en && !clear) begin
            mem_q[ptr_q] <= din;
        end
    end

    assign dout = (fill_q == FILL_FULL) ? mem_q[ptr_q] : '0;

endmodule

// File: rtl/schmidl_cox_metric.sv
// Four-stage Schmidl-Cox metric M[n] = |sum x[n-k]*conj(x[n-k-L])|^2 with a single stall enable.
// Sample and metric streams are emitted in lockstep; a beat leaves only when both readies are high.
module schmidl_cox_metric
    import schmidl_cox_pkg::*;
#(
    parameter int HALF_FFT_SIZE = 512,
    parameter int M_TDATA_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [31:0]              i_tdata,
    input  logic                     i_tlast,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    output logic [31:0]              o_tdata,
    output logic                     o_tlast,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic [M_TDATA_WIDTH-1:0] m_tdata,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready
);
    localparam int LOG2_L = $clog2(HALF_FFT_SIZE);
    localparam int ACC_W  = acc_width(HALF_FFT_SIZE);
    localparam int EXT_W  = ACC_W - PROD_W;

    if (M_TDATA_WIDTH != 64 || HALF_FFT_SIZE < 4 ||
        (HALF_FFT_SIZE & (HALF_FFT_SIZE - 1)) != 0) begin : g_bad_params
        $error("schmidl_cox_metric: need M_TDATA_WIDTH=64 and power-of-two HALF_FFT_SIZE >= 4");
    end

    logic en, accept;
    logic rdy_q, rdy_d;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic l1_q, l1_d, l2_q, l2_d, l3_q, l3_d, l4_q, l4_d;
    cplx_t x1_q, x1_d, d1_q, d1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
    cplx_prod_t p2_q, p2_d;
    logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [63:0] m4_q, m4_d;

    cplx_t      dl_sample;
    cplx_prod_t dl_prod;
    cplx_prod_t prod;
    logic signed [31:0] ii, qq, qi, iq, pq_re, pq_im;
    logic unused_acc_lsbs;

    assign en       = !v4_q || (o_tready && m_tready);
    assign i_tready = en && rdy_q;
    assign accept   = i_tvalid && i_tready;

    sc_delay_line #(.DEPTH(HALF_FFT_SIZE), .WIDTH($bits(cplx_t))) u_sample_line (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (accept && !clear),
        .din   (i_tdata),
        .dout  (dl_sample)
    );

    // Products are retired from the window as the matching sample moves from S2 into S3.
    sc_delay_line #(.DEPTH(HALF_FFT_SIZE), .WIDTH($bits(cplx_prod_t))) u_prod_line (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (en && v2_q && !clear),
        .din   (p2_q),
        .dout  (dl_prod)
    );

    always_comb begin
        ii      = mul_s16(x1_q.re, d1_q.re);
        qq      = mul_s16(x1_q.im, d1_q.im);
        qi      = mul_s16(x1_q.im, d1_q.re);
        iq      = mul_s16(x1_q.re, d1_q.im);
        prod.re = {ii[31], ii} + {qq[31], qq};
        prod.im = {qi[31], qi} - {iq[31], iq};
    end

    // Dividing by 2L keeps the squared metric within 64 bits.
    assign pq_re = acc_re_q[ACC_W-1:LOG2_L+1];
    assign pq_im = acc_im_q[ACC_W-1:LOG2_L+1];
    assign unused_acc_lsbs = ^{acc_re_q[LOG2_L:0], acc_im_q[LOG2_L:0]};

    always_comb begin
        rdy_d    = 1'b1;
        v1_d = v1_q; v2_d = v2_q; v3_d = v3_q; v4_d = v4_q;
        l1_d = l1_q; l2_d = l2_q; l3_d = l3_q; l4_d = l4_q;
        x1_d = x1_q; d1_d = d1_q; x2_d = x2_q; x3_d = x3_q; x4_d = x4_q;
        p2_d     = p2_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        m4_d     = m4_q;
        if (clear) begin
            v1_d = 1'b0; v2_d = 1'b0; v3_d = 1'b0; v4_d = 1'b0;
            l1_d = 1'b0; l2_d = 1'b0; l3_d = 1'b0; l4_d = 1'b0;
            x1_d = '0; d1_d = '0; x2_d = '0; x3_d = '0; x4_d = '0;
            p2_d     = '0;
            acc_re_d = '0;
            acc_im_d = '0;
            m4_d     = '0;
        end else if (en) begin
            v1_d = accept;
            x1_d = i_tdata;
            l1_d = i_tlast;
            d1_d = dl_sample;
            v2_d = v1_q;
            x2_d = x1_q;
            l2_d = l1_q;
            p2_d = prod;
            v3_d = v2_q;
            x3_d = x2_q;
            l3_d = l2_q;
            if (v2_q) begin
                acc_re_d = acc_re_q + {{EXT_W{p2_q.re[PROD_W-1]}}, p2_q.re}
                                    - {{EXT_W{dl_prod.re[PROD_W-1]}}, dl_prod.re};
                acc_im_d = acc_im_q + {{EXT_W{p2_q.im[PROD_W-1]}}, p2_q.im}
                                    - {{EXT_W{dl_prod.im[PROD_W-1]}}, dl_prod.im};
            end
            v4_d = v3_q;
            x4_d = x3_q;
            l4_d = l3_q;
            m4_d = sq_s32(pq_re) + sq_s32(pq_im);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q <= 1'b0;
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
            l1_q <= 1'b0; l2_q <= 1'b0; l3_q <= 1'b0; l4_q <= 1'b0;
            x1_q <= '0; d1_q <= '0; x2_q <= '0; x3_q <= '0; x4_q <= '0;
            p2_q     <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            m4_q     <= '0;
        end else begin
            rdy_q <= rdy_d;
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d;
            l1_q <= l1_d; l2_q <= l2_d; l3_q <= l3_d; l4_q <= l4_d;
            x1_q <= x1_d; d1_q <= d1_d; x2_q <= x2_d; x3_q <= x3_d; x4_q <= x4_d;
            p2_q     <= p2_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            m4_q     <= m4_d;
        end
    end

    assign o_tdata  = x4_q;
    assign o_tlast  = l4_q;
    assign o_tvalid = v4_q;
    assign m_tdata  = m4_q;
    assign m_tlast  = l4_q;
    assign m_tvalid = v4_q;

endmodule

// File: tb/tb_schmidl_cox_metric.sv
// Self-checking bench for schmidl_cox_metric with L=8, using a direct-sum golden model.
// Valid/ready: a beat transfers on a rising edge where valid and ready (both readies on output) are high.
module tb_schmidl_cox_metric;
    localparam int L     = 8;
    localparam int SHIFT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [63:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;

    schmidl_cox_metric #(.HALF_FFT_SIZE(L), .M_TDATA_WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [96:0] exp_q[$];
    int          acc_cyc_q[$];
    logic [31:0] hist[$];
    logic [63:0] mlog[$];
    int          cyc = 0;
    int          last_cnt = 0;
    bit          lat_chk = 1'b0;
    int          rdy_mode = 0;
    bit          hold_v = 1'b0;
    logic [96:0] hold_val;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Direct window sum over the accepted history since the last reset/clear.
    function automatic logic [63:0] model_m();
        int     n;
        longint pr;
        longint pi;
        longint qr;
        longint qi;
        n  = hist.size() - 1;
        pr = 0;
        pi = 0;
        for (int k = 0; k < L; k++) begin
            int a;
            int b;
            logic signed [15:0] xi, xq, di, dq;
            a = n - k;
            b = n - k - L;
            if (b >= 0) begin
                xi = hist[a][31:16];
                xq = hist[a][15:0];
                di = hist[b][31:16];
                dq = hist[b][15:0];
                pr += longint'(xi) * longint'(di) + longint'(xq) * longint'(dq);
                pi += longint'(xq) * longint'(di) - longint'(xi) * longint'(dq);
            end
        end
        qr = longint'(int'(pr >>> SHIFT));
        qi = longint'(int'(pi >>> SHIFT));
        return 64'(qr * qr + qi * qi);
    endfunction

    always @(negedge clk) begin
        if (!reset || clear) begin
            exp_q.delete();
            acc_cyc_q.delete();
            hist.delete();
            mlog.delete();
            hold_v = 1'b0;
        end else begin
            logic [96:0] e;
            int          ac;
            cyc++;
            chk("m_tvalid_lockstep", m_tvalid, o_tvalid);
            if (hold_v) begin
                chk("hold_valid", o_tvalid, 1);
                chk("hold_sample", {o_tlast, o_tdata}, hold_val[96:64]);
                chk("hold_metric", m_tdata, hold_val[63:0]);
            end
            if (i_tvalid && i_tready) begin
                hist.push_back(i_tdata);
                exp_q.push_back({i_tlast, i_tdata, model_m()});
                acc_cyc_q.push_back(cyc);
            end
            if (o_tvalid && o_tready && m_tready) begin
                hold_v = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ac = acc_cyc_q.pop_front();
                    chk("o_tdata", o_tdata, e[95:64]);
                    chk("o_tlast", o_tlast, e[96]);
                    chk("m_tlast", m_tlast, e[96]);
                    chk("m_tdata", m_tdata, e[63:0]);
                    if (lat_chk) chk("latency", cyc - ac, 4);
                    mlog.push_back(m_tdata);
                    if (o_tlast) last_cnt++;
                end
            end else if (o_tvalid) begin
                hold_v   = 1'b1;
                hold_val = {o_tlast, o_tdata, m_tdata};
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    o_tready = ($urandom_range(0, 3) != 0);
                    m_tready = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    o_tready = 1'b0;
                    m_tready = 1'b1;
                end
                default: begin
                    o_tready = 1'b1;
                    m_tready = 1'b1;
                end
            endcase
        end
    end

    task automatic drive_beat(input logic [31:0] data, input logic last);
        bit done;
        done     = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = data;
        i_tlast  = last;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            done = i_tready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle_cycle();
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        i_tvalid = 1'b0;
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 0);
    endtask

    task automatic do_clear();
        i_tvalid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_o_tvalid", o_tvalid, 0);
        chk("clear_m_tvalid", m_tvalid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_last;
        reset    = 1'b0;
        i_tvalid = 1'b1;
        i_tdata  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_i_tready", i_tready, 0);
        chk("rst_o_tdata", o_tdata, 0);
        chk("rst_m_tdata", m_tdata, 0);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        i_tvalid = 1'b0;
        #1;
        chk("rdy_at_release", i_tready, 0);
        @(posedge clk);
        #1;
        chk("rdy_after_release", i_tready, 1);

        lat_chk = 1'b1;
        for (int i = 0; i < 24; i++) drive_beat({16'd1000, 16'd0}, 1'b0);
        drain();
        lat_chk = 1'b0;
        chk("a_count", 64'(mlog.size()), 24);
        chk("a_m7", mlog[7], 0);
        chk("a_m8", mlog[8], 64'd3906250000);
        chk("a_m12", mlog[12], 64'd97656250000);
        chk("a_m15", mlog[15], 64'd250000000000);
        chk("a_m23", mlog[23], 64'd250000000000);
        do_clear();

        for (int i = 0; i < 20; i++) drive_beat(32'h8000_8000, 1'b0);
        drain();
        chk("b_m7", mlog[7], 0);
        chk("b_m19", mlog[19], 64'h1000_0000_0000_0000);
        do_clear();

        fork
            begin
                for (int i = 0; i < 40; i++) drive_beat($urandom, 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                rdy_mode = 2;
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("stall_i_tready", i_tready, 0);
                chk("stall_o_tvalid", o_tvalid, 1);
                repeat (4) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        base_last = last_cnt;
        rdy_mode  = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            drive_beat($urandom, (i % 20) == 19);
        end
        drain();
        rdy_mode = 0;
        chk("d_tlast_count", 64'(last_cnt - base_last), 3);

        do_clear();
        for (int i = 0; i < 30; i++) drive_beat($urandom, 1'b0);
        do_clear();
        for (int i = 0; i < 20; i++) drive_beat($urandom, 1'b0);
        drain();
        chk("e_count", 64'(mlog.size()), 20);
        for (int k = 0; k < 8; k++) chk("e_zero_after_clear", mlog[k], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
